seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider: the inverse of the arithmetic unit's multiply path, and the real division it lacks. It computes X / Y one quotient bit per clock and returns the quotient and remainder packed in the same 8-bit `out` format the arithmetic unit drives. A start/busy/done handshake connects it to the arithmetic unit's operation select. Divide-by-zero is flagged on a dedicated output that drives the error LED.

---
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Results are packed as {remainder, quotient}; Y=0 short-circuits to DONE with an error flag.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_dvd;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Trial needs WIDTH+1 bits; after a successful subtract the result is < divisor,
  // so the low WIDTH bits of the difference are exact.
  assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_dvs) : w_trial[WIDTH-1:0];
  assign w_q_nxt   = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_q     <= w_q_nxt;
            r_r     <= w_rem_nxt;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            if (Y == '0) begin
              r_q     <= '1;
              r_r     <= X;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= X;
              r_dvs   <= Y;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
              r_cnt   <= CW'(WIDTH);
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign quotient    = r_q;
  assign remainder   = r_r;
  assign out         = {r_r, r_q};
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, hand-computed divisions, divide-by-zero,
// ignored start, mid-run reset, back-to-back issue and a full operand sweep.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] X, Y;
  logic [W-1:0] quotient, remainder;
  logic [2*W-1:0] out;
  logic         busy, done, div_by_zero;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y),
    .quotient(quotient), .remainder(remainder), .out(out),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to its done pulse.
  task automatic run_div(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    int cyc, nb;
    start = 1'b1; X = x; Y = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nb = 0;
    while (!done && cyc < 30) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"},  32'(cyc),  (y == 0) ? 32'd1 : 32'(W + 1));
    chk({tag, ".nbusy"}, 32'(nb),  (y == 0) ? 32'd0 : 32'(W));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".q"},    32'(quotient),  32'(eq));
    chk({tag, ".r"},    32'(remainder), 32'(er));
    chk({tag, ".out"},  32'(out), 32'({er, eq}));
    chk({tag, ".dbz"},  32'(div_by_zero), (y == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int cyc, prev, seen;
    logic [W-1:0] bx [4];
    logic [W-1:0] by [4];
    logic [W-1:0] bq [4];
    logic [W-1:0] br [4];

    reset = 1'b1; start = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    chk("rst.q",    32'(quotient), 32'd0);
    chk("rst.r",    32'(remainder), 32'd0);
    chk("rst.out",  32'(out), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dbz",  32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1);
    chk("d13_3.out_hex", 32'(out), 32'h14);
    @(negedge clk);
    chk("hold.done", 32'(done), 32'd0);
    chk("hold.out",  32'(out), 32'h14);

    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0);
    chk("d15_1.out_hex", 32'(out), 32'h0F);
    run_div("d3_9", 4'd3, 4'd9, 4'd0, 4'd3);
    chk("d3_9.out_hex", 32'(out), 32'h30);

    run_div("d7_0", 4'd7, 4'd0, 4'hF, 4'd7);
    @(negedge clk);
    chk("dbz.hold", 32'(div_by_zero), 32'd1);
    chk("dbz.idle_done", 32'(done), 32'd0);
    run_div("d9_2", 4'd9, 4'd2, 4'd4, 4'd1);

    // start during RUN with new operands must not disturb 13/3
    start = 1'b1; X = 4'd13; Y = 4'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; X = 4'd8; Y = 4'd2;
    @(negedge clk); start = 1'b0;
    cyc = 3;
    while (!done && cyc < 30) begin @(negedge clk); cyc++; end
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.lat",  32'(cyc), 32'(W + 1));
    chk("ign.q",    32'(quotient), 32'd4);
    chk("ign.r",    32'(remainder), 32'd1);
    @(negedge clk);
    chk("ign.no_requeue", 32'(busy | done), 32'd0);

    // Reset in the middle of 14/5
    start = 1'b1; X = 4'd14; Y = 4'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.out",  32'(out), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (done || busy) seen++; end
    chk("mid.quiet", 32'(seen), 32'd0);
    run_div("d14_5", 4'd14, 4'd5, 4'd2, 4'd4);
    chk("d14_5.out_hex", 32'(out), 32'h42);

    // Back-to-back with start held high
    bx = '{4'd13, 4'd14, 4'd15, 4'd3};
    by = '{4'd3,  4'd5,  4'd1,  4'd9};
    bq = '{4'd4,  4'd2,  4'd15, 4'd0};
    br = '{4'd1,  4'd4,  4'd0,  4'd3};
    start = 1'b1; X = bx[0]; Y = by[0];
    cyc = 0; prev = 0;
    for (int k = 0; k < 4; k++) begin
      do begin @(negedge clk); cyc++; end while (!done && cyc < 100);
      chk("b2b.done", 32'(done), 32'd1);
      chk("b2b.period", 32'(cyc - prev), 32'(W + 1));
      chk("b2b.q", 32'(quotient), 32'(bq[k]));
      chk("b2b.r", 32'(remainder), 32'(br[k]));
      prev = cyc;
      if (k < 3) begin X = bx[k+1]; Y = by[k+1]; end
      else start = 1'b0;
    end
    @(negedge clk);

    // Full sweep against the arithmetic definition
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        if (y == 0) run_div("sweep", 4'(x), 4'(y), 4'hF, 4'(x));
        else        run_div("sweep", 4'(x), 4'(y), 4'(x / y), 4'(x % y));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
